// File: rtl/cordic_dds_ctrl.sv
// ============================================================================
// Module   : cordic_dds_ctrl
// Purpose  : Phase accumulator, quadrant fold and latency-matched sign fix-up
//            wrapped around a pipelined CORDIC sin/cos core (full-circle DDS).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_dds_ctrl #(
    parameter int CORDIC_LAT = 14,
    parameter int W          = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_cfg_valid,
    output logic                o_cfg_ready,
    input  logic [W-1:0]        i_cfg_ftw,
    input  logic [W-1:0]        i_cfg_phase,
    input  logic                i_enable,
    output logic                o_busy,
    output logic [W-1:0]        o_cordic_angle,
    input  logic signed [W-1:0] i_cordic_sin,
    input  logic signed [W-1:0] i_cordic_cos,
    output logic signed [W-1:0] o_sin_out,
    output logic signed [W-1:0] o_cos_out,
    output logic                o_out_valid
);

    localparam int CW = $clog2(CORDIC_LAT + 1);
    localparam logic signed [W-1:0] C_SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] C_SMAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t              r_state;
    logic [W-1:0]        r_acc;
    logic [W-1:0]        r_ftw;
    logic [W-1:0]        r_angle;
    logic [CORDIC_LAT:0] r_valid_d;
    logic [CORDIC_LAT:0] r_fold_d;
    logic [CW-1:0]       r_flush_cnt;
    logic signed [W-1:0] r_sin;
    logic signed [W-1:0] r_cos;
    logic                r_out_valid;

    logic                w_issue;
    logic                w_fold;
    logic [W-1:0]        w_fold_angle;

    // Outside +/-pi/2 the angle is rotated by pi; the result is negated later.
    assign w_fold       = r_acc[W-1] ^ r_acc[W-2];
    assign w_fold_angle = {r_acc[W-1] ^ w_fold, r_acc[W-2:0]};
    assign w_issue      = (r_state == S_RUN) && i_enable;

    function automatic logic signed [W-1:0] f_neg_sat(input logic signed [W-1:0] v);
        if (v == C_SMIN)
            return C_SMAX;
        return -v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_ftw       <= '0;
            r_angle     <= '0;
            r_valid_d   <= '0;
            r_fold_d    <= '0;
            r_flush_cnt <= '0;
            r_sin       <= '0;
            r_cos       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_valid_d   <= {r_valid_d[CORDIC_LAT-1:0], w_issue};
            r_fold_d    <= {r_fold_d[CORDIC_LAT-1:0], w_issue & w_fold};
            r_out_valid <= r_valid_d[CORDIC_LAT];

            if (r_valid_d[CORDIC_LAT]) begin
                r_sin <= r_fold_d[CORDIC_LAT] ? f_neg_sat(i_cordic_sin) : i_cordic_sin;
                r_cos <= r_fold_d[CORDIC_LAT] ? f_neg_sat(i_cordic_cos) : i_cordic_cos;
            end

            if (w_issue) begin
                r_angle <= w_fold_angle;
                r_acc   <= r_acc + r_ftw;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_cfg_valid) begin
                        r_ftw   <= i_cfg_ftw;
                        r_acc   <= i_cfg_phase;
                        r_state <= S_LOAD;
                    end else if (i_enable) begin
                        r_state <= S_RUN;
                    end
                end
                S_LOAD: begin
                    r_state <= i_enable ? S_RUN : S_IDLE;
                end
                S_RUN: begin
                    if (!i_enable) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= '0;
                    end
                end
                S_FLUSH: begin
                    // Hold long enough for the last issued sample to reach the output.
                    if (r_flush_cnt == CW'(CORDIC_LAT)) begin
                        r_state     <= S_IDLE;
                        r_flush_cnt <= '0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cfg_ready    = (r_state == S_IDLE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_cordic_angle = r_angle;
    assign o_sin_out      = r_sin;
    assign o_cos_out      = r_cos;
    assign o_out_valid    = r_out_valid;

endmodule

`default_nettype wire
